// File: rtl/alu_seq_control.sv
// alu_seq_control
// Sequencing controller for the multi-cycle ALU datapath (add, sub, Booth
// radix-2 multiply, non-restoring divide). The datapath owns A, Q, Q[-1] and M;
// this block only walks the operation through its steps and raises one strobe
// per datapath function each cycle.
//
// Ports
//   clk, reset       rising-edge clock, asynchronous active-high reset
//   start, op        request + opcode (00 add, 01 sub, 10 mul, 11 div),
//                    accepted only in IDLE
//   a_msb, q0, q_m1  datapath status: sign of A, Q[0], Booth extra bit Q[-1]
//   divisor_zero     M == 0, checked before a divide starts iterating
//   busy, done       handshake: busy outside IDLE, done one cycle in DONE
//   err_div0         sticky divide-by-zero flag, cleared by the next start
//   iter             current multiply/divide iteration index
//   ctrl[10:0]       datapath strobes, see C_* indices below
module alu_seq_control #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             a_msb,
  input  logic             q0,
  input  logic             q_m1,
  input  logic             divisor_zero,
  output logic             busy,
  output logic             done,
  output logic             err_div0,
  output logic [CNT_W-1:0] iter,
  output logic [10:0]      ctrl
);

  // State encoding
  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_LD_M   = 4'd1;
  localparam logic [3:0] S_LD_Q   = 4'd2;
  localparam logic [3:0] S_EXEC   = 4'd3;
  localparam logic [3:0] S_M_TEST = 4'd4;
  localparam logic [3:0] S_M_SHR  = 4'd5;
  localparam logic [3:0] S_D_SHL  = 4'd6;
  localparam logic [3:0] S_D_ALU  = 4'd7;
  localparam logic [3:0] S_D_SETQ = 4'd8;
  localparam logic [3:0] S_D_CORR = 4'd9;
  localparam logic [3:0] S_OUT_A  = 4'd10;
  localparam logic [3:0] S_OUT_Q  = 4'd11;
  localparam logic [3:0] S_ERR    = 4'd12;
  localparam logic [3:0] S_DONE   = 4'd13;

  // Opcodes
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  // Strobe indices
  localparam int C_LOAD_M   = 0;
  localparam int C_LOAD_Q   = 1;
  localparam int C_ADD_M    = 2;
  localparam int C_SUB_M    = 3;
  localparam int C_ASR      = 4;
  localparam int C_SHL      = 5;
  localparam int C_SET_Q0   = 6;
  localparam int C_CORR_ADD = 7;
  localparam int C_OUT_A    = 8;
  localparam int C_OUT_Q    = 9;
  localparam int C_CLR_A    = 10;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  logic [3:0] state;
  logic [3:0] state_nx;
  logic [1:0] op_r;
  logic       last_iter;
  logic       accept;

  assign last_iter = (iter == LAST_ITER);
  assign accept    = (state == S_IDLE) && start;

  // Next state
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start) state_nx = S_LD_M;
      S_LD_M:   state_nx = S_LD_Q;
      S_LD_Q: begin
        if (!op_r[1])             state_nx = S_EXEC;
        else if (op_r == OP_MUL)  state_nx = S_M_TEST;
        else if (divisor_zero)    state_nx = S_ERR;
        else                      state_nx = S_D_SHL;
      end
      S_EXEC:   state_nx = S_OUT_A;
      S_M_TEST: state_nx = S_M_SHR;
      S_M_SHR:  state_nx = last_iter ? S_OUT_A : S_M_TEST;
      S_D_SHL:  state_nx = S_D_ALU;
      S_D_ALU:  state_nx = S_D_SETQ;
      S_D_SETQ: state_nx = last_iter ? S_D_CORR : S_D_SHL;
      S_D_CORR: state_nx = S_OUT_A;
      S_OUT_A:  state_nx = op_r[1] ? S_OUT_Q : S_DONE;
      S_OUT_Q:  state_nx = S_DONE;
      S_ERR:    state_nx = S_DONE;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // State, captured opcode, iteration counter, error flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      op_r     <= 2'b00;
      iter     <= '0;
      err_div0 <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_r     <= op;
        iter     <= '0;
        err_div0 <= 1'b0;
      end
      // Counter advances at the end of each iteration except the last, so it
      // rests at WIDTH-1 once the loop exits.
      if ((state == S_M_SHR || state == S_D_SETQ) && !last_iter)
        iter <= iter + CNT_W'(1);
      // Set on the edge that enters ERR so the flag is already visible while
      // the controller sits in ERR.
      if (state == S_LD_Q && op_r == OP_DIV && divisor_zero)
        err_div0 <= 1'b1;
    end
  end

  // Strobes: decoded from state, qualified by live datapath status
  always_comb begin
    ctrl = '0;
    case (state)
      S_LD_M: ctrl[C_LOAD_M] = 1'b1;
      S_LD_Q: begin
        ctrl[C_LOAD_Q] = 1'b1;
        ctrl[C_CLR_A]  = 1'b1;
      end
      S_EXEC: begin
        if (op_r[0]) ctrl[C_SUB_M] = 1'b1;
        else         ctrl[C_ADD_M] = 1'b1;
      end
      // Booth pair {Q0,Q-1}: 01 -> +M, 10 -> -M, 00/11 -> nothing
      S_M_TEST: begin
        case ({q0, q_m1})
          2'b01:   ctrl[C_ADD_M] = 1'b1;
          2'b10:   ctrl[C_SUB_M] = 1'b1;
          default: ctrl = '0;
        endcase
      end
      S_M_SHR: ctrl[C_ASR] = 1'b1;
      S_D_SHL: ctrl[C_SHL] = 1'b1;
      // Non-restoring step: negative partial remainder adds M back
      S_D_ALU: begin
        if (a_msb) ctrl[C_ADD_M] = 1'b1;
        else       ctrl[C_SUB_M] = 1'b1;
      end
      S_D_SETQ: ctrl[C_SET_Q0]   = !a_msb;
      S_D_CORR: ctrl[C_CORR_ADD] = a_msb;
      S_OUT_A:  ctrl[C_OUT_A]    = 1'b1;
      S_OUT_Q:  ctrl[C_OUT_Q]    = 1'b1;
      default:  ctrl = '0;
    endcase
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule

// File: doc/alu_seq_control.md
Name: alu_seq_control

Overview:
- Parameterised sequencing control unit for the N-bit multi-cycle ALU datapath: add, subtract, Booth radix-2 multiply, and non-restoring divide.
- Generalises the fixed 8-bit controller:
  - operand width is set by a parameter;
  - the iteration counter is internal, with no external count input;
  - a start/busy/done handshake is added;
  - divide-by-zero is detected and the operation is aborted.
- Drives one-hot datapath control strobes each cycle, based on the state and on status bits from the datapath.

Parameters:
- WIDTH, 8, operand width in bits (>= 2); sets the multiply/divide iteration count.
- CNT_W, $clog2(WIDTH), width of the internal iteration counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request to begin an operation; sampled only in IDLE.
- op  in  2  operation: 00 add, 01 sub, 10 mul, 11 div; captured into op_r when start is accepted.
- a_msb  in  1  sign bit of accumulator A, combinational from the datapath.
- q0  in  1  Q[0].
- q_m1  in  1  Booth extra bit Q[-1].
- divisor_zero  in  1  high when register M == 0.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse in the DONE state.
- err_div0  out  1  sticky divide-by-zero flag; cleared on the next accepted start.
- iter  out  CNT_W  current iteration index, for debug and verification.
- ctrl  out  11  one-hot-per-function strobes:
  - [0] load_m
  - [1] load_q
  - [2] add_m (A <= A+M)
  - [3] sub_m (A <= A-M)
  - [4] asr_booth (A,Q,Q-1 arithmetic shift right)
  - [5] shl_div (A,Q shift left)
  - [6] set_q0
  - [7] corr_add (final A <= A+M)
  - [8] out_a
  - [9] out_q
  - [10] clr_a

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - state goes to IDLE; busy, done, err_div0, iter and ctrl are all 0;
  - no done pulse is generated for the aborted operation.
- Outputs are Moore-style from the state, qualified combinationally by op_r, a_msb, q0 and q_m1 as listed below.
- op is ignored after capture. start is ignored while busy, including in DONE.
- States and strobes:
  - IDLE: on start, capture op_r, clear err_div0 and iter, go to LD_M.
  - LD_M: ctrl[0]; go to LD_Q.
  - LD_Q: ctrl[1] and ctrl[10]. Next state:
    - op_r 0x goes to EXEC;
    - op_r 10 goes to M_TEST;
    - op_r 11 goes to ERR if divisor_zero, otherwise D_SHL.
  - EXEC: ctrl[2] for add, ctrl[3] for sub; go to OUT_A.
  - M_TEST: {q0,q_m1}=01 asserts ctrl[2]; =10 asserts ctrl[3]; 00 or 11 asserts no strobe. Go to M_SHR.
  - M_SHR: ctrl[4]. If iter == WIDTH-1, go to OUT_A; otherwise iter++ and go to M_TEST. This gives exactly WIDTH iterations.
  - D_SHL: ctrl[5]; go to D_ALU.
  - D_ALU: a_msb=1 asserts ctrl[2], otherwise ctrl[3]; go to D_SETQ.
  - D_SETQ: ctrl[6] if a_msb=0 (new sign). If iter == WIDTH-1, go to D_CORR; otherwise iter++ and go to D_SHL.
  - D_CORR: ctrl[7] if a_msb=1; go to OUT_A.
  - OUT_A: ctrl[8]. Add/sub go to DONE; mul/div go to OUT_Q.
  - OUT_Q: ctrl[9]; go to DONE.
  - ERR: err_div0 <= 1; no strobes; go to DONE.
  - DONE: done=1; go to IDLE.
- Latency, counted from the start-accept edge to the cycle in which done is high:
  - add/sub: 5 cycles;
  - mul: 2*WIDTH+5 cycles (21 at WIDTH=8);
  - div: 3*WIDTH+6 cycles (30 at WIDTH=8);
  - div by zero: 4 cycles.
- Strobe exclusivity: at most one of ctrl[2], ctrl[3] and ctrl[7] is high in any cycle; ctrl[4] and ctrl[5] are never high together.
- iter wraps only through the explicit clear on start; it holds its value from the final iteration until the next start.

Test Plan:
- op=00, start pulse: ctrl sequence is [0], [1]+[10], [2], [8]; done high at cycle 5; busy high for cycles 1-5.
- op=10, WIDTH=8, Q=0b10110011 with Q-1=0: ctrl[2]/ctrl[3] pattern matches the Booth pairs; exactly 8 ctrl[4] pulses; done at cycle 21.
- op=11, WIDTH=8, A sign sequence driven by a datapath model for 100/7: 8 ctrl[5] pulses; ctrl[6] count equals the quotient 14's set bits; ctrl[7] only if the final remainder is negative; done at cycle 30.
- op=11 with divisor_zero=1: no ctrl[5] pulses; err_div0=1 from cycle 3 onward; done at cycle 4; next start clears err_div0.
- reset asserted during M_SHR at iteration 3: outputs go to 0 immediately (asynchronously); no done pulse; a fresh start afterwards runs a full 21-cycle multiply.
- start held high continuously, and op toggled mid-run: no re-trigger while busy; the captured op is honoured; a second operation begins only in the cycle after DONE.
- WIDTH=16 regression: mul done at 37 cycles, div done at 54 cycles.
